// File: rtl/jt08_adpcm_dec_if.sv
// Slot bus between the channel sequencer, the ADPCM-A decoder and the channel accumulator.
interface jt08_adpcm_dec_if;
    logic        cen;
    logic [5:0]  cur_ch;
    logic [5:0]  chon;
    logic [5:0]  clr;
    logic        adv;
    logic [3:0]  data;
    logic [15:0] pcm_out;
    logic        en_sum;
    logic [5:0]  out_ch;

    modport master (
        output cen, cur_ch, chon, clr, adv, data,
        input  pcm_out, en_sum, out_ch
    );

    modport slave (
        input  cen, cur_ch, chon, clr, adv, data,
        output pcm_out, en_sum, out_ch
    );
endinterface

// File: rtl/jt08_adpcm_dec.sv
// Six-channel time-multiplexed ADPCM-A decoder: one nibble per slot, output one slot later.
module jt08_adpcm_dec #(
    parameter int MAXIDX = 48
) (
    input  logic             rst,
    input  logic             clk,
    jt08_adpcm_dec_if.slave  bus
);

    logic signed [11:0] acc [6];
    logic        [5:0]  idx [6];

    logic               one_hot;
    logic [2:0]         k;
    logic               chon_k;
    logic               clr_k;
    logic signed [11:0] sel_acc;
    logic [5:0]         sel_idx;
    logic [10:0]        step;
    logic [14:0]        prod;
    logic [12:0]        delta;
    logic signed [13:0] acc_ext;
    logic signed [13:0] sum;
    logic signed [11:0] sat;
    logic signed [6:0]  adj;
    logic signed [6:0]  idx_sum;
    logic [5:0]         idx_new;
    logic               decode;
    logic               write_en;
    logic signed [11:0] next_acc;
    logic [5:0]         next_idx;

    function automatic logic [10:0] step_of(input logic [5:0] i);
        case (i)
            6'd0:  step_of = 11'd16;   6'd1:  step_of = 11'd17;
            6'd2:  step_of = 11'd19;   6'd3:  step_of = 11'd21;
            6'd4:  step_of = 11'd23;   6'd5:  step_of = 11'd25;
            6'd6:  step_of = 11'd28;   6'd7:  step_of = 11'd31;
            6'd8:  step_of = 11'd34;   6'd9:  step_of = 11'd37;
            6'd10: step_of = 11'd41;   6'd11: step_of = 11'd45;
            6'd12: step_of = 11'd50;   6'd13: step_of = 11'd55;
            6'd14: step_of = 11'd60;   6'd15: step_of = 11'd66;
            6'd16: step_of = 11'd73;   6'd17: step_of = 11'd80;
            6'd18: step_of = 11'd88;   6'd19: step_of = 11'd97;
            6'd20: step_of = 11'd107;  6'd21: step_of = 11'd118;
            6'd22: step_of = 11'd130;  6'd23: step_of = 11'd143;
            6'd24: step_of = 11'd157;  6'd25: step_of = 11'd173;
            6'd26: step_of = 11'd190;  6'd27: step_of = 11'd209;
            6'd28: step_of = 11'd230;  6'd29: step_of = 11'd253;
            6'd30: step_of = 11'd279;  6'd31: step_of = 11'd307;
            6'd32: step_of = 11'd337;  6'd33: step_of = 11'd371;
            6'd34: step_of = 11'd408;  6'd35: step_of = 11'd449;
            6'd36: step_of = 11'd494;  6'd37: step_of = 11'd544;
            6'd38: step_of = 11'd598;  6'd39: step_of = 11'd658;
            6'd40: step_of = 11'd724;  6'd41: step_of = 11'd796;
            6'd42: step_of = 11'd876;  6'd43: step_of = 11'd963;
            6'd44: step_of = 11'd1060; 6'd45: step_of = 11'd1166;
            6'd46: step_of = 11'd1282; 6'd47: step_of = 11'd1411;
            default: step_of = 11'd1552;
        endcase
    endfunction

    always_comb begin
        k = 3'd0;
        for (int i = 0; i < 6; i++)
            if (bus.cur_ch[i]) k = 3'(i);
    end

    assign one_hot = $onehot(bus.cur_ch);
    assign chon_k  = bus.chon[k];
    assign clr_k   = bus.clr[k];
    assign sel_acc = acc[k];
    assign sel_idx = idx[k];

    // delta = floor(step * (2*mag+1) / 8); the product of an 11-bit step and a 4-bit odd factor fits 15 bits
    assign step    = step_of(sel_idx);
    assign prod    = 15'(step) * 15'({bus.data[2:0], 1'b1});
    assign delta   = 13'(prod >> 3);
    assign acc_ext = 14'(sel_acc);
    assign sum     = bus.data[3] ? acc_ext - $signed({1'b0, delta})
                                 : acc_ext + $signed({1'b0, delta});

    always_comb begin
        if (sum > 14'sd2047)
            sat = 12'sd2047;
        else if (sum < -14'sd2048)
            sat = -12'sd2048;
        else
            sat = sum[11:0];
    end

    always_comb begin
        case (bus.data[2:0])
            3'd4:    adj = 7'sd2;
            3'd5:    adj = 7'sd5;
            3'd6:    adj = 7'sd7;
            3'd7:    adj = 7'sd9;
            default: adj = -7'sd1;
        endcase
    end

    assign idx_sum = $signed({1'b0, sel_idx}) + adj;

    always_comb begin
        if (idx_sum < 7'sd0)
            idx_new = 6'd0;
        else if (idx_sum > $signed(7'(MAXIDX)))
            idx_new = 6'(MAXIDX);
        else
            idx_new = idx_sum[5:0];
    end

    // clr wins over a nibble; a nibble on a keyed-off channel is dropped
    assign decode   = bus.adv && chon_k;
    assign write_en = one_hot && (clr_k || decode);

    always_comb begin
        next_acc = sel_acc;
        next_idx = sel_idx;
        if (clr_k) begin
            next_acc = 12'sd0;
            next_idx = 6'd0;
        end else if (decode) begin
            next_acc = sat;
            next_idx = idx_new;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) begin
                acc[i] <= 12'sd0;
                idx[i] <= 6'd0;
            end
            bus.pcm_out <= 16'd0;
            bus.en_sum  <= 1'b0;
            bus.out_ch  <= 6'd0;
        end else if (bus.cen) begin
            for (int i = 0; i < 6; i++) begin
                if (write_en && k == 3'(i)) begin
                    acc[i] <= next_acc;
                    idx[i] <= next_idx;
                end
            end
            bus.out_ch <= bus.cur_ch;
            if (one_hot && chon_k) begin
                bus.pcm_out <= {next_acc, 4'b0000};
                bus.en_sum  <= 1'b1;
            end else begin
                bus.pcm_out <= 16'd0;
                bus.en_sum  <= 1'b0;
            end
        end
    end

endmodule
